// File: rtl/ppa_32.sv
// ppa_32: registered 32-bit Kogge-Stone parallel-prefix adder, {Cout, S} = A + B + Cin
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears S and Cout
//   A, B  : 32-bit addends
//   Cin   : carry-in (weight 2^0)
//   S     : registered 32-bit sum
//   Cout  : registered carry-out of bit 31
module ppa_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cin,
    output logic [31:0] S,
    output logic        Cout
);
    logic [31:0] g0;
    logic [31:0] p0;
    logic [31:0] c;
    logic [31:0] sum;
    assign g0 = A & B;
    assign p0 = A ^ B;
    // Each level k combines with the node 2^k positions below. Propagate terms
    // are only kept for bits that still need them: a bit whose span already
    // reaches position 0 holds its final carry, so its P is never read again.
    for (genvar k = 0; k < 5; k++) begin : lvl
        localparam int SPAN = 1 << k;
        logic [31:0]    gi;
        logic [31:0]    go;
        logic [31:SPAN] pi;
        if (k == 0) begin : src
            // Cin is folded in as a generate entering below bit 0
            assign gi = {g0[31:1], g0[0] | (p0[0] & Cin)};
            assign pi = p0[31:1];
        end else begin : src
            assign gi = lvl[k-1].go;
            assign pi = lvl[k-1].pp.po;
        end
        for (genvar i = 0; i < 32; i++) begin : gc
            if (i >= SPAN) begin : blk
                assign go[i] = gi[i] | (pi[i] & gi[i-SPAN]);
            end else begin : buf_
                assign go[i] = gi[i];
            end
        end
        if (k < 4) begin : pp
            logic [31:2*SPAN] po;
            for (genvar i = 2 * SPAN; i < 32; i++) begin : pc
                assign po[i] = pi[i] & pi[i-SPAN];
            end
        end
    end
    // c[i] is the carry out of bit i, Cin included
    assign c   = lvl[4].go;
    assign sum = p0 ^ {c[30:0], Cin};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S    <= 32'h0;
            Cout <= 1'b0;
        end else begin
            S    <= sum;
            Cout <= c[31];
        end
    end
endmodule

// File: tb/tb_ppa_32.sv
// tb_ppa_32: self-checking bench for ppa_32 against a 33-bit arithmetic reference
module tb_ppa_32;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Cin = 1'b0;
    logic [31:0] S;
    logic        Cout;
    int checks = 0;
    int fails = 0;

    ppa_32 dut (.clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin), .S(S), .Cout(Cout));

    always #5 clk = ~clk;

    function automatic logic [32:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic ci);
        return {1'b0, a} + {1'b0, b} + {32'b0, ci};
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci);
        @(negedge clk);
        A = a;
        B = b;
        Cin = ci;
    endtask

    task automatic test_reset;
        A = 32'hFFFFFFFF;
        B = 32'hFFFFFFFF;
        Cin = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Cout, S} !== 33'h0) begin
            fails++;
            $display("FAIL reset_initial: got Cout=%b S=%h, want Cout=0 S=00000000", Cout, S);
        end
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({Cout, S} !== 33'h0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got Cout=%b S=%h, want Cout=0 S=00000000", n, Cout, S);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (S !== 32'hFFFFFFFF || Cout !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: got Cout=%b S=%h, want Cout=1 S=ffffffff", Cout, S);
        end
    endtask

    // fixed vectors with hand-derived expectations: {A, B, Cin, Cout, S}
    task automatic test_directed;
        logic [97:0] vec [7];
        vec[0] = {32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000};
        vec[1] = {32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003};
        vec[2] = {32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b1, 32'h00000000};
        vec[3] = {32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b1, 32'h00000000};
        vec[4] = {32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 32'hACF13568};
        vec[5] = {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF};
        vec[6] = {32'h80000000, 32'h80000000, 1'b0, 1'b1, 32'h00000000};
        for (int n = 0; n < 7; n++) begin
            drive(vec[n][97:66], vec[n][65:34], vec[n][33]);
            @(posedge clk);
            #1;
            checks++;
            if ({Cout, S} !== vec[n][32:0]) begin
                fails++;
                $display("FAIL directed[%0d]: got Cout=%b S=%h, want Cout=%b S=%h",
                         n, Cout, S, vec[n][32], vec[n][31:0]);
            end
        end
    endtask

    // new vector every cycle: before the edge the previous result must still show,
    // right after it the new one, and mid-cycle input changes must not leak through
    task automatic test_back_to_back;
        logic [32:0] prev;
        logic [32:0] cur;
        logic [31:0] a;
        logic [31:0] b;
        logic ci;
        prev = {Cout, S};
        for (int n = 0; n < 20; n++) begin
            a = $urandom;
            b = $urandom;
            ci = 1'($urandom_range(1));
            drive(a, b, ci);
            cur = ref_add(a, b, ci);
            #1;
            checks++;
            if ({Cout, S} !== prev) begin
                fails++;
                $display("FAIL b2b_before[%0d]: got %h, want %h", n, {Cout, S}, prev);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({Cout, S} !== cur) begin
                fails++;
                $display("FAIL b2b_after[%0d]: got %h, want %h", n, {Cout, S}, cur);
            end
            A = ~a;
            #2;
            checks++;
            if ({Cout, S} !== cur) begin
                fails++;
                $display("FAIL b2b_midcycle[%0d]: got %h, want %h", n, {Cout, S}, cur);
            end
            prev = cur;
        end
    endtask

    task automatic test_reset_midstream;
        logic [32:0] exp;
        drive(32'hDEADBEEF, 32'h21524111, 1'b1);
        @(posedge clk);
        #1;
        exp = ref_add(32'hDEADBEEF, 32'h21524111, 1'b1);
        checks++;
        if ({Cout, S} !== exp) begin
            fails++;
            $display("FAIL mid_pre: got %h, want %h", {Cout, S}, exp);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({Cout, S} !== 33'h0) begin
            fails++;
            $display("FAIL mid_async_clear: got %h, want 000000000", {Cout, S});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({Cout, S} !== 33'h0) begin
            fails++;
            $display("FAIL mid_hold: got %h, want 000000000", {Cout, S});
        end
        drive(32'h7FFFFFFF, 32'h00000001, 1'b0);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({Cout, S} !== 33'h0) begin
            fails++;
            $display("FAIL mid_release_wait: got %h, want 000000000", {Cout, S});
        end
        @(posedge clk);
        #1;
        checks++;
        if ({Cout, S} !== 33'h080000000) begin
            fails++;
            $display("FAIL mid_resume: got %h, want 080000000", {Cout, S});
        end
    endtask

    task automatic test_random;
        logic [32:0] q[$];
        logic [32:0] exp;
        logic [31:0] a;
        logic [31:0] b;
        logic ci;
        for (int n = 0; n < 10000; n++) begin
            a = $urandom;
            b = $urandom;
            ci = 1'($urandom_range(1));
            if (n % 8 == 1) a = ~b;
            if (n % 8 == 2) b = 32'hFFFFFFFF;
            drive(a, b, ci);
            q.push_back(ref_add(a, b, ci));
            @(posedge clk);
            #1;
            exp = q.pop_front();
            checks++;
            if ({Cout, S} !== exp) begin
                fails++;
                $display("FAIL random[%0d]: A=%h B=%h Cin=%b got %h, want %h", n, a, b, ci, {Cout, S}, exp);
            end
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_back_to_back;
        test_reset_midstream;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
